// File: rtl/qkv_lane_sram_pkg.sv
// ----------------------------------------------------------------------------
// qkv_lane_sram_pkg
// Shared types and helpers for the banked Q/K/V activation store:
//   - state_e      : sweep FSM states
//   - RD_LAT_MIN/MAX, rd_lat_ok() : legal read-pipeline depths
//   - addr_width() : row-address width for a given bank depth (minimum 1)
//   - lane_off()   : bit offset of lane L inside a flat per-lane bus
// ----------------------------------------------------------------------------
package qkv_lane_sram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic bit rd_lat_ok(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int lane_off(input int lane, input int w);
        return lane * w;
    endfunction

endpackage

// File: rtl/qkv_lane_sram_if.sv
// ----------------------------------------------------------------------------
// qkv_lane_sram_if
// Write/read/clear bus of the lane store. All per-lane fields are flat
// vectors; lane L sits at [L*W +: W].
//   wr_en/wr_addr/wr_data : per-lane write port
//   rd_en                 : lockstep read request for all lanes
//   rd_addr               : per-lane read address
//   rd_data/rd_valid      : per-lane read rows and their strobe
//   clr_start/busy        : clear sweep request and in-progress flag
// master = producer/consumer side, slave = the store.
// ----------------------------------------------------------------------------
interface qkv_lane_sram_if
    import qkv_lane_sram_pkg::*;
#(
    parameter int NUM_MAT = 3,
    parameter int NUM_CH  = 16,
    parameter int DEPTH   = 64,
    parameter int ELEM_W  = 20,
    parameter int ELEMS   = 4,
    parameter int ADDR_W  = addr_width(DEPTH)
);
    localparam int NL    = NUM_MAT * NUM_CH;
    localparam int ROW_W = ELEMS * ELEM_W;

    logic [NL-1:0]          wr_en;
    logic [NL*ADDR_W-1:0]   wr_addr;
    logic [NL*ROW_W-1:0]    wr_data;
    logic                   rd_en;
    logic [NL*ADDR_W-1:0]   rd_addr;
    logic [NL*ROW_W-1:0]    rd_data;
    logic                   rd_valid;
    logic                   clr_start;
    logic                   busy;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, clr_start,
        input  rd_data, rd_valid, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, clr_start,
        output rd_data, rd_valid, busy
    );
endinterface

// File: rtl/qkv_lane_sram_lane_bank.sv
// ----------------------------------------------------------------------------
// qkv_lane_sram_lane_bank
// One lane's DEPTH x ROW_W bank, one write and one read per cycle.
//   i_wr_en/i_wr_addr/i_wr_data : write port (out-of-range address dropped)
//   i_rd_en/i_rd_addr           : read request (out-of-range returns zero)
//   o_rd_data                   : read row after RD_LAT cycles, zero otherwise
// A same-address write and read in one cycle returns the new write data.
// ----------------------------------------------------------------------------
module qkv_lane_sram_lane_bank #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int ROW_W  = 80,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [ROW_W-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [ROW_W-1:0]  o_rd_data
);
    // One extra bit so DEPTH itself is representable for the range compare.
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    logic [ROW_W-1:0]             r_mem [DEPTH];
    logic [RD_LAT-1:0][ROW_W-1:0] r_pipe;
    logic                         w_wr_ok;
    logic                         w_rd_ok;
    logic                         w_fwd;
    logic [ROW_W-1:0]             w_rd_row;

    assign w_wr_ok = i_wr_en && ({1'b0, i_wr_addr} < DEPTH_W);
    assign w_rd_ok = i_rd_en && ({1'b0, i_rd_addr} < DEPTH_W);
    assign w_fwd   = w_wr_ok && (i_wr_addr == i_rd_addr);

    // Storage is deliberately not reset; only a clear sweep zeroes it.
    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[i_wr_addr] <= i_wr_data;
    end

    always_comb begin
        w_rd_row = '0;
        if (w_rd_ok) w_rd_row = w_fwd ? i_wr_data : r_mem[i_rd_addr];
    end

    // Idle cycles load zero, so the output is zero whenever no read is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= w_rd_row;
            for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_rd_data = r_pipe[RD_LAT-1];
endmodule

// File: rtl/qkv_lane_sram.sv
// ----------------------------------------------------------------------------
// qkv_lane_sram
// NUM_MAT*NUM_CH independent lane banks (Q/K/V x channels) with lockstep
// reads, per-lane writes and a hardware clear sweep.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of qkv_lane_sram_if (write/read/clear ports)
// The top owns the IDLE/CLEAR FSM, the clear row counter and the rd_valid
// pipeline; while clearing, every bank's write port is borrowed by the sweep.
// ----------------------------------------------------------------------------
module qkv_lane_sram
    import qkv_lane_sram_pkg::*;
#(
    parameter int NUM_MAT = 3,
    parameter int NUM_CH  = 16,
    parameter int DEPTH   = 64,
    parameter int ELEM_W  = 20,
    parameter int ELEMS   = 4,
    parameter int ADDR_W  = addr_width(DEPTH),
    parameter int RD_LAT  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    qkv_lane_sram_if.slave bus
);
    localparam int              NL       = NUM_MAT * NUM_CH;
    localparam int              ROW_W    = ELEMS * ELEM_W;
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);

    if (!rd_lat_ok(RD_LAT)) begin : g_rd_lat_chk
        $error("qkv_lane_sram: RD_LAT must be 1 or 2");
    end

    state_e            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_clr_row, w_clr_row_nxt;
    logic              w_clearing;
    logic              w_rd_acc;
    logic [RD_LAT:1]   r_vld_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_clr_row <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_row <= w_clr_row_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_row_nxt = r_clr_row;
        case (r_state)
            IDLE: begin
                if (bus.clr_start) begin
                    w_state_nxt   = CLEAR;
                    w_clr_row_nxt = '0;
                end
            end
            CLEAR: begin
                if (r_clr_row == LAST_ROW) begin
                    w_state_nxt   = IDLE;
                    w_clr_row_nxt = '0;
                end else begin
                    w_clr_row_nxt = r_clr_row + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_clearing = (r_state == CLEAR);
    assign w_rd_acc   = bus.rd_en && !w_clearing;

    // Reads accepted before a sweep still drain through this pipe normally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe[1] <= w_rd_acc;
            for (int i = 2; i <= RD_LAT; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
        end
    end

    assign bus.rd_valid = r_vld_pipe[RD_LAT];
    assign bus.busy     = w_clearing;

    for (genvar l = 0; l < NL; l++) begin : g_lane
        localparam int AO = lane_off(l, ADDR_W);
        localparam int RO = lane_off(l, ROW_W);

        logic              w_we;
        logic [ADDR_W-1:0] w_wa;
        logic [ROW_W-1:0]  w_wd;

        // Sweep overrides user writes; user writes only land in IDLE.
        assign w_we = w_clearing | bus.wr_en[l];
        assign w_wa = w_clearing ? r_clr_row : bus.wr_addr[AO +: ADDR_W];
        assign w_wd = w_clearing ? '0 : bus.wr_data[RO +: ROW_W];

        qkv_lane_sram_lane_bank #(
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W),
            .ROW_W  (ROW_W),
            .RD_LAT (RD_LAT)
        ) u_bank (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_wr_en   (w_we),
            .i_wr_addr (w_wa),
            .i_wr_data (w_wd),
            .i_rd_en   (w_rd_acc),
            .i_rd_addr (bus.rd_addr[AO +: ADDR_W]),
            .o_rd_data (bus.rd_data[RO +: ROW_W])
        );
    end
endmodule
